// File: rtl/i2c_rx_frame_deserializer.sv
// Serial frame receiver: 8 data bits MSB first plus one even-parity bit, sampled from
// synchronized SCL/SDA, delivered through a one-entry holding register released by READ_ACK.
module i2c_rx_frame_deserializer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       ENABLE,
    input  logic       SCL_IN,
    input  logic       SDA_IN,
    input  logic       READ_ACK,
    output logic [7:0] DATA_OUT,
    output logic       PARITY_BIT,
    output logic       REG_FULL,
    output logic       OVERRUN,
    output logic       FRAME_ERROR,
    output logic       BUS_ACTIVE,
    output logic       o_dbg_state
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift;

    logic       w_scl;
    logic       w_sda;
    logic       w_scl_rise;
    logic       w_start;
    logic       w_stop;
    logic       w_frame_done;
    logic [8:0] w_frame;

    // Synchronizers reset to 1 so an idle bus produces no spurious edges after reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], SCL_IN};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], SDA_IN};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    // The ninth bit is taken live from SDA, so the stored shift register only needs 8 bits.
    assign w_frame      = {r_shift, w_sda};
    assign w_frame_done = ENABLE && (r_state == ST_ACTIVE) && w_scl_rise && (r_bit_cnt == 4'd8);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'h00;
            BUS_ACTIVE  <= 1'b0;
            FRAME_ERROR <= 1'b0;
        end else begin
            FRAME_ERROR <= 1'b0;
            if (!ENABLE) begin
                r_state    <= ST_IDLE;
                r_bit_cnt  <= 4'd0;
                BUS_ACTIVE <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_start) begin
                            r_state    <= ST_ACTIVE;
                            r_bit_cnt  <= 4'd0;
                            BUS_ACTIVE <= 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_start || w_stop) begin
                            FRAME_ERROR <= (r_bit_cnt != 4'd0);
                            r_bit_cnt   <= 4'd0;
                            if (w_stop) begin
                                r_state    <= ST_IDLE;
                                BUS_ACTIVE <= 1'b0;
                            end
                        end else if (w_scl_rise) begin
                            r_shift   <= {r_shift[6:0], w_sda};
                            r_bit_cnt <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A READ_ACK coinciding with a completion frees the slot for the new frame instead.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            DATA_OUT   <= 8'h00;
            PARITY_BIT <= 1'b0;
            REG_FULL   <= 1'b0;
            OVERRUN    <= 1'b0;
        end else if (w_frame_done) begin
            if (!REG_FULL || READ_ACK) begin
                DATA_OUT   <= w_frame[8:1];
                PARITY_BIT <= w_frame[0];
                REG_FULL   <= 1'b1;
            end else begin
                OVERRUN <= 1'b1;
            end
        end else if (READ_ACK && REG_FULL) begin
            REG_FULL <= 1'b0;
            OVERRUN  <= 1'b0;
        end
    end

    assign o_dbg_state = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_i2c_rx_frame_deserializer.sv
// Directed bench for i2c_rx_frame_deserializer: bus-level frame driver, expected-frame
// queue popped by a monitor on every holding-register load, and direct flag checks.
module tb_i2c_rx_frame_deserializer;

  localparam int SYNC_STAGES = 2;
  localparam int H = SYNC_STAGES + 3;

  logic       CLK;
  logic       RESET_N;
  logic       ENABLE;
  logic       SCL_IN;
  logic       SDA_IN;
  logic       READ_ACK;
  logic [7:0] DATA_OUT;
  logic       PARITY_BIT;
  logic       REG_FULL;
  logic       OVERRUN;
  logic       FRAME_ERROR;
  logic       BUS_ACTIVE;
  logic       o_dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int ferr_cycles = 0;
  logic [8:0] exp_q[$];

  i2c_rx_frame_deserializer #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .ENABLE(ENABLE),
    .SCL_IN(SCL_IN),
    .SDA_IN(SDA_IN),
    .READ_ACK(READ_ACK),
    .DATA_OUT(DATA_OUT),
    .PARITY_BIT(PARITY_BIT),
    .REG_FULL(REG_FULL),
    .OVERRUN(OVERRUN),
    .FRAME_ERROR(FRAME_ERROR),
    .BUS_ACTIVE(BUS_ACTIVE),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b, input logic ack_at_rise);
    SCL_IN = 1'b0;
    wait_cyc(H);
    SDA_IN = b;
    wait_cyc(H);
    SCL_IN = 1'b1;
    if (ack_at_rise) begin
      wait_cyc(SYNC_STAGES);
      READ_ACK = 1'b1;
      wait_cyc(1);
      READ_ACK = 1'b0;
      wait_cyc(H - SYNC_STAGES - 1);
    end else begin
      wait_cyc(H);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic ack_last);
    for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
    send_bit(p, ack_last);
  endtask

  task automatic send_start();
    SCL_IN = 1'b0;
    wait_cyc(H);
    SDA_IN = 1'b1;
    wait_cyc(H);
    SCL_IN = 1'b1;
    wait_cyc(H);
    SDA_IN = 1'b0;
    wait_cyc(H);
  endtask

  // Called with SCL high; a high SDA is first pulled low (a harmless repeated start at bit 0).
  task automatic send_stop();
    if (SDA_IN) begin
      SDA_IN = 1'b0;
      wait_cyc(H);
    end
    SDA_IN = 1'b1;
    wait_cyc(H + SYNC_STAGES);
  endtask

  task automatic pulse_ack();
    READ_ACK = 1'b1;
    wait_cyc(1);
    READ_ACK = 1'b0;
    wait_cyc(2);
  endtask

  // scoreboard monitor: a load is REG_FULL rising, or new contents while it stays full
  logic       prev_full = 1'b0;
  logic [8:0] prev_word = 9'h000;
  always @(negedge CLK) begin
    logic [8:0] w;
    if (RESET_N) begin
      if (FRAME_ERROR) ferr_cycles++;
      if (REG_FULL && (!prev_full || ({DATA_OUT, PARITY_BIT} != prev_word))) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_unexpected_load: got %0h, expected no load", {DATA_OUT, PARITY_BIT});
        end else begin
          w = exp_q.pop_front();
          check("sb_frame", {23'd0, DATA_OUT, PARITY_BIT}, {23'd0, w});
        end
      end
    end
    prev_full = REG_FULL;
    prev_word = {DATA_OUT, PARITY_BIT};
  end

  initial begin
    RESET_N  = 1'b0;
    ENABLE   = 1'b1;
    SCL_IN   = 1'b1;
    SDA_IN   = 1'b1;
    READ_ACK = 1'b0;
    wait_cyc(3);
    RESET_N = 1'b1;
    wait_cyc(3);

    check("rst_data", {24'd0, DATA_OUT}, 32'h00);
    check("rst_parity", {31'd0, PARITY_BIT}, 32'd0);
    check("rst_full", {31'd0, REG_FULL}, 32'd0);
    check("rst_overrun", {31'd0, OVERRUN}, 32'd0);
    check("rst_ferr", {31'd0, FRAME_ERROR}, 32'd0);
    check("rst_busact", {31'd0, BUS_ACTIVE}, 32'd0);

    // single frame A5 / p0
    exp_q.push_back({8'hA5, 1'b0});
    send_start();
    check("busact_after_start", {31'd0, BUS_ACTIVE}, 32'd1);
    check("dbg_active", {31'd0, o_dbg_state}, 32'd1);
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_full", {31'd0, REG_FULL}, 32'd1);
    send_stop();
    check("a5_busact_after_stop", {31'd0, BUS_ACTIVE}, 32'd0);
    check("dbg_idle", {31'd0, o_dbg_state}, 32'd0);
    pulse_ack();
    check("a5_ack_full", {31'd0, REG_FULL}, 32'd0);

    // back-to-back 3C then FF with no ack: FF dropped, overrun set
    exp_q.push_back({8'h3C, 1'b0});
    send_start();
    send_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0);
    send_stop();
    check("ovr_data_kept", {24'd0, DATA_OUT}, 32'h3C);
    check("ovr_set", {31'd0, OVERRUN}, 32'd1);
    check("ovr_full", {31'd0, REG_FULL}, 32'd1);
    pulse_ack();
    check("ovr_ack_full", {31'd0, REG_FULL}, 32'd0);
    check("ovr_ack_clear", {31'd0, OVERRUN}, 32'd0);

    // 18 then 81 with READ_ACK in the completion cycle of 81
    exp_q.push_back({8'h18, 1'b0});
    exp_q.push_back({8'h81, 1'b0});
    send_start();
    send_frame(8'h18, 1'b0, 1'b0);
    send_frame(8'h81, 1'b0, 1'b1);
    check("sim_ack_data", {24'd0, DATA_OUT}, 32'h81);
    check("sim_ack_full", {31'd0, REG_FULL}, 32'd1);
    check("sim_ack_overrun", {31'd0, OVERRUN}, 32'd0);
    send_stop();

    // STOP after 5 bits while 81 is held
    send_start();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_stop();
    check("ferr_one_cycle", ferr_cycles, 32'd1);
    check("ferr_full_kept", {31'd0, REG_FULL}, 32'd1);
    check("ferr_data_kept", {24'd0, DATA_OUT}, 32'h81);
    pulse_ack();
    exp_q.push_back({8'h01, 1'b1});
    send_start();
    send_frame(8'h01, 1'b1, 1'b0);
    send_stop();
    check("p1_parity", {31'd0, PARITY_BIT}, 32'd1);
    check("p1_no_ferr", ferr_cycles, 32'd1);
    pulse_ack();

    // hold 55, then disable and drive a frame that must be ignored
    exp_q.push_back({8'h55, 1'b0});
    send_start();
    send_frame(8'h55, 1'b0, 1'b0);
    send_stop();
    ENABLE = 1'b0;
    send_start();
    check("dis_busact", {31'd0, BUS_ACTIVE}, 32'd0);
    send_frame(8'hAA, 1'b0, 1'b0);
    send_stop();
    check("dis_data_kept", {24'd0, DATA_OUT}, 32'h55);
    check("dis_full_kept", {31'd0, REG_FULL}, 32'd1);
    check("dis_no_overrun", {31'd0, OVERRUN}, 32'd0);
    ENABLE = 1'b1;
    wait_cyc(H);

    // asynchronous reset after 4 bits of a frame
    send_start();
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_data", {24'd0, DATA_OUT}, 32'h00);
    check("arst_full", {31'd0, REG_FULL}, 32'd0);
    check("arst_busact", {31'd0, BUS_ACTIVE}, 32'd0);
    check("arst_ferr", {31'd0, FRAME_ERROR}, 32'd0);
    @(negedge CLK);
    SCL_IN = 1'b1;
    SDA_IN = 1'b1;
    wait_cyc(3);
    RESET_N = 1'b1;
    wait_cyc(3);
    exp_q.push_back({8'h7E, 1'b0});
    send_start();
    send_frame(8'h7E, 1'b0, 1'b0);
    send_stop();
    check("arst_7e_data", {24'd0, DATA_OUT}, 32'h7E);
    check("arst_7e_full", {31'd0, REG_FULL}, 32'd1);
    check("arst_no_ferr", ferr_cycles, 32'd1);

    wait_cyc(4);
    check("sb_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
